// File: rtl/l1_cache_control.sv
// l1_cache_control: control FSM for the 2-way, 8-set L1 cache (hit service, writeback, fill, event counters)
// Ports: clk/rst; CPU side mem_read/mem_write/mem_resp; memory side pmem_read/pmem_write/pmem_resp;
// datapath flags hit/dirty; array read/load strobes, data_load, dirty_in, addr_sel, data_sel;
// counter_clear and hit_count/miss_count/wb_count performance counters.
module l1_cache_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   input  logic             hit,
   input  logic             dirty,
   output logic             tag_read,
   output logic             valid_read,
   output logic             dirty_read,
   output logic             data_read,
   output logic             lru_read,
   output logic             tag_load,
   output logic             valid_load,
   output logic             dirty_load,
   output logic             lru_load,
   output logic [1:0]       data_load,
   output logic             dirty_in,
   output logic             addr_sel,
   output logic             data_sel,
   input  logic             counter_clear,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);
   typedef enum logic [2:0] {IDLE, CHECK, WB, FILL, REFRESH} state_t;
   state_t state_q, state_d;
   logic refill_q, refill_d;
   logic req, rd_all, hit_inc, miss_inc, wb_inc;
   assign req = mem_read | mem_write;
   assign {tag_read, valid_read, dirty_read, data_read, lru_read} = {5{rd_all}};
   // refill_q marks the CHECK that follows a fill so its hit is not counted again
   assign refill_d = (state_q == FILL && pmem_resp) || (refill_q && state_d != IDLE);
   assign hit_inc  = state_q == CHECK && req && hit && !refill_q;
   assign miss_inc = state_q == CHECK && req && !hit;
   assign wb_inc   = state_q == WB && pmem_resp;
   always_comb begin
      state_d    = state_q;
      rd_all     = 1'b0;
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      tag_load   = 1'b0;
      valid_load = 1'b0;
      dirty_load = 1'b0;
      lru_load   = 1'b0;
      data_load  = 2'b00;
      dirty_in   = 1'b0;
      addr_sel   = 1'b0;
      data_sel   = 1'b0;
      case (state_q)
         IDLE: begin
            rd_all  = 1'b1;
            state_d = req ? CHECK : IDLE;
         end
         CHECK: begin
            if (!req) begin
               state_d = IDLE;
            end else if (hit) begin
               mem_resp   = 1'b1;
               lru_load   = 1'b1;
               data_load  = mem_write ? 2'b01 : 2'b00;
               dirty_load = mem_write;
               dirty_in   = mem_write;
               state_d    = IDLE;
            end else begin
               state_d = dirty ? WB : FILL;
            end
         end
         WB: begin
            addr_sel   = 1'b1;
            pmem_write = 1'b1;
            state_d    = pmem_resp ? FILL : WB;
         end
         FILL: begin
            data_sel   = 1'b1;
            pmem_read  = 1'b1;
            data_load  = pmem_resp ? 2'b10 : 2'b00;
            tag_load   = pmem_resp;
            valid_load = pmem_resp;
            dirty_load = pmem_resp;
            state_d    = pmem_resp ? REFRESH : FILL;
         end
         REFRESH: begin
            rd_all  = 1'b1;
            state_d = CHECK;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         refill_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         refill_q <= refill_d;
      end
   end
   always_ff @(posedge clk) begin
      if (rst || counter_clear) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         hit_count  <= hit_count + CNT_W'(hit_inc);
         miss_count <= miss_count + CNT_W'(miss_inc);
         wb_count   <= wb_count + CNT_W'(wb_inc);
      end
   end
endmodule

// File: doc/l1_cache_control.md
Name: l1_cache_control

Overview:
Control FSM for the 2-way, 8-set, 256-bit-line L1 cache datapath. It accepts one CPU-side read or write request at a time and drives the datapath's array read/load strobes, mux selects and dirty input. It sequences hit service, dirty-victim writeback and line fill over the physical-memory handshake. Hit, miss and writeback events are counted for performance monitoring.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  one-cycle completion pulse to CPU
pmem_read  out  1  line-fill request to memory
pmem_write  out  1  writeback request to memory
pmem_resp  in  1  one-cycle memory completion pulse
hit  in  1  datapath hit flag, valid in CHECK
dirty  in  1  datapath victim-dirty flag, valid in CHECK
tag_read, valid_read, dirty_read, data_read, lru_read  out  1 each  array read strobes
tag_load, valid_load, dirty_load, lru_load  out  1 each  array load strobes
data_load  out  2  00 none, 01 byte-enabled CPU write, 10 full-line fill
dirty_in  out  1  value written to dirty array
addr_sel  out  1  0 = CPU line address, 1 = victim writeback address
data_sel  out  1  0 = CPU write data, 1 = pmem_rdata
counter_clear  in  1  synchronous clear of all counters
hit_count, miss_count, wb_count  out  CNT_W each  event counters

Behaviour:
- One clock (clk). Synchronous active-high reset (rst). Outputs decode combinationally from the state and the inputs. Any output not listed for a state is 0.
- States: IDLE, CHECK, WB, FILL, REFRESH. Reset -> IDLE and all counters 0, regardless of the current state. pmem_read/pmem_write drop in the cycle after rst is sampled.
- IDLE: all five read strobes = 1. (mem_read | mem_write) -> CHECK; otherwise stay.
- CHECK: all read strobes = 0, so the array outputs and the way selection stay stable.
  - hit & mem_write: data_load=01, data_sel=0, dirty_load=1, dirty_in=1, lru_load=1, mem_resp=1 -> IDLE.
  - hit & mem_read only: lru_load=1, mem_resp=1 -> IDLE.
  - Both mem_read and mem_write high: serviced as a write.
  - !hit & dirty -> WB. !hit & !dirty -> FILL.
  - Neither request high (request withdrawn): no loads, no resp -> IDLE.
- WB: addr_sel=1, pmem_write=1, held until pmem_resp. On pmem_resp -> FILL.
- FILL: addr_sel=0, data_sel=1, pmem_read=1. On the pmem_resp cycle, also assert data_load=10, tag_load=1, valid_load=1, dirty_load=1, dirty_in=0 -> REFRESH.
- REFRESH: all read strobes = 1 (re-read the updated set) -> CHECK. The repeat CHECK hits and completes the request.
- Once entered, WB and FILL always run to pmem_resp, even if the CPU request drops. pmem_read and pmem_write are never asserted together.
- Counters:
  - hit_count +1 on a first-pass hit in CHECK only (the post-fill hit is not counted).
  - miss_count +1 on each CHECK->WB or CHECK->FILL transition.
  - wb_count +1 on WB exit.
  - Counters wrap modulo 2^CNT_W. counter_clear takes priority over increments in the same cycle.
- Latency:
  - Hit: mem_resp 1 cycle after the request is first sampled in IDLE.
  - Clean miss: IDLE, CHECK, FILL (until pmem_resp), REFRESH, CHECK(resp).
  - Dirty miss: adds WB before FILL.
- mem_resp is high for exactly one cycle per serviced request. A request still high in the cycle after mem_resp is sampled as a new request.

Test Plan:
- Reset with mem_read=1 -> state IDLE, read strobes=1, all other outputs and counters 0; CHECK entered on the next cycle.
- Read hit (hit=1 in CHECK) -> mem_resp at cycle 2, lru_load=1, data_load=00, hit_count=1, miss_count=0.
- Write hit with byte enables -> data_load=01, dirty_load=1, dirty_in=1, mem_resp same cycle.
- Clean read miss with pmem_resp after 5 cycles -> pmem_read high 5 cycles, addr_sel=0; fill cycle data_load=10, tag/valid load=1, dirty_in=0; REFRESH; CHECK with hit=1 -> mem_resp; miss_count=1, hit_count=0.
- Dirty write miss -> WB with addr_sel=1 and pmem_write until pmem_resp, then FILL, then byte-enabled write; wb_count=1, miss_count=1.
- rst asserted mid-FILL -> pmem_read=0 next cycle, state IDLE, counters 0. counter_clear together with a hit -> hit_count=0.
